alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SHALL be: MULDIV_LAT, default 4, EXEC cycles held for ALUOp_MUL/ALUOp_DIV (legal range 1..15).
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 req_valid  in  2  per-requester request strobe; bit i = requester i.
REQ-006 req_ready  out  2  per-requester accept; at most one bit high.
REQ-007 req_op  in  10  ALUOp per requester, [5i+4:5i].
REQ-008 req_a  in  64  operand 1 per requester, [32i+31:32i].
REQ-009 req_b  in  64  operand 2 per requester, [32i+31:32i].
REQ-010 req_shamt  in  10  shift amount per requester, [5i+4:5i].
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumer accept.
REQ-013 rsp_id  out  1  index of requester owning response.
REQ-014 rsp_res  out  32  captured ALURes.
REQ-015 rsp_zero  out  1  captured Zero (BNE polarity as produced by ALU).
REQ-016 rsp_err  out  1  op rejected (undefined ALUOp or DIV by zero).
REQ-017 alu_in1, alu_in2  out  32 each  drive ALU DataIn1/DataIn2.
REQ-018 alu_shamt  out  5  drives ALU shamt; alu_op  out  5  drives ALU ALUOp.
REQ-019 alu_res  in  32  ALU ALURes; alu_zero  in  1  ALU Zero.

Function
REQ-020 FSM SHALL have states IDLE, EXEC, RESP.
REQ-021 In IDLE, req_ready SHALL be one-hot to the grant winner when any req_valid is high, else 0; req_ready SHALL be 0 in EXEC and RESP.
REQ-022 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; pointer updates only on accept.
REQ-023 On accept (valid&ready), op/a/b/shamt/id SHALL be registered; ALU ports driven only from these registers, never from req_* directly.
REQ-024 Accept of a defined op other than MUL/DIV SHALL enter EXEC for exactly 1 cycle; MUL/DIV SHALL stay MULDIV_LAT cycles via down-counter.
REQ-025 On the last EXEC cycle, alu_res/alu_zero SHALL be captured into rsp_res/rsp_zero, rsp_err=0, and state SHALL go to RESP.
REQ-026 Latency: accept at cycle T -> rsp_valid at T+2 (single-cycle ops), T+1+MULDIV_LAT (MUL/DIV).
REQ-027 Undefined ALUOp, or ALUOp_DIV with b==0, SHALL bypass EXEC: RESP at T+1 with rsp_res=0, rsp_zero=1, rsp_err=1.
REQ-028 In RESP, rsp_valid=1 and rsp_* SHALL hold stable until rsp_ready; rsp_valid&rsp_ready -> IDLE next cycle.
REQ-029 Requests SHALL not be accepted in RESP even with rsp_ready high (max throughput one op per 3 cycles).
REQ-030 Requesters SHALL hold req_* stable while valid and not ready; arbiter behaviour otherwise is undefined.
REQ-031 rsp_valid SHALL be 0 in IDLE and EXEC.

Reset
REQ-032 rst_n low at a clock edge SHALL force IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_zero=0, rsp_err=0, counter=0, RR pointer=1 (requester 0 wins first), alu_* registers=0.
REQ-033 Reset mid-EXEC or mid-RESP SHALL discard the operation; no response is ever issued for it.

Structure
REQ-034 ALUOp codes SHALL come from the shared signal_def definitions; FSM state encoding and MULDIV_LAT default SHALL live in the shared package.
REQ-035 Round-robin grant logic SHALL be one sub-module rr_arb2 (inputs req[1:0], last; output gnt[1:0]); ALU is instantiated outside the arbiter.

Verification
REQ-036 After reset, req_valid=2'b11 both ADD (3+4, 10+5) -> req0 granted first, rsp_id=0 res=7; then rsp_id=1 res=15.
REQ-037 req0 SUB 5-5 accepted at T, rsp_ready=1 -> rsp_valid at T+2, res=0, zero=1; BNE 5-5 -> zero=0.
REQ-038 req1 MUL 6*7, MULDIV_LAT=4 -> rsp_valid at T+5, res=42; req0 held valid meanwhile sees req_ready=0.
REQ-039 req0 DIV 9/0 -> rsp_valid at T+1, res=0, zero=1, err=1; undefined op 5'h1F -> same.
REQ-040 rsp_ready held 0 for 5 cycles -> rsp_* stable; rst_n pulsed low during EXEC -> no rsp_valid, pointer back to 1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALUOp codes, FSM states,
// request payload and op classification helpers.
package alu_arbiter_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned OPW            = 5;
  localparam int unsigned SHW            = 5;
  localparam int unsigned CNTW           = 4;
  localparam int unsigned MULDIV_LAT_DEF = 4;

  // ALUOp codes shared with the ALU; anything above ALUOp_BNE is undefined
  localparam logic [OPW-1:0] ALUOp_ADD  = 5'h00;
  localparam logic [OPW-1:0] ALUOp_SUB  = 5'h01;
  localparam logic [OPW-1:0] ALUOp_AND  = 5'h02;
  localparam logic [OPW-1:0] ALUOp_OR   = 5'h03;
  localparam logic [OPW-1:0] ALUOp_XOR  = 5'h04;
  localparam logic [OPW-1:0] ALUOp_SLL  = 5'h05;
  localparam logic [OPW-1:0] ALUOp_SRL  = 5'h06;
  localparam logic [OPW-1:0] ALUOp_SRA  = 5'h07;
  localparam logic [OPW-1:0] ALUOp_SLT  = 5'h08;
  localparam logic [OPW-1:0] ALUOp_SLTU = 5'h09;
  localparam logic [OPW-1:0] ALUOp_MUL  = 5'h0A;
  localparam logic [OPW-1:0] ALUOp_DIV  = 5'h0B;
  localparam logic [OPW-1:0] ALUOp_BEQ  = 5'h0C;
  localparam logic [OPW-1:0] ALUOp_BNE  = 5'h0D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [SHW-1:0]  shamt;
  } alu_req_t;

  function automatic logic op_defined(input logic [OPW-1:0] op);
    return op <= ALUOp_BNE;
  endfunction

  function automatic logic op_muldiv(input logic [OPW-1:0] op);
    return (op == ALUOp_MUL) || (op == ALUOp_DIV);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ALU, holding each op in registers
// for its execution latency and presenting a registered response handshake.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*OPW-1:0]  req_op,
  input  logic [2*XLEN-1:0] req_a,
  input  logic [2*XLEN-1:0] req_b,
  input  logic [2*SHW-1:0]  req_shamt,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_res,
  output logic            rsp_zero,
  output logic            rsp_err,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [SHW-1:0]  alu_shamt,
  output logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_zero
);

  arb_state_e      state_q, state_d;
  logic            last_q, last_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  alu_req_t        opreg_q, opreg_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_res_q, rsp_res_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_err_q, rsp_err_d;

  logic [1:0]      gnt;
  logic            win_id;
  logic            accept;
  alu_req_t        win_req;

  rr_arb2 u_rr (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt)
  );

  assign win_id = gnt[1];

  // Payload of the grant winner, selected from the flattened request buses
  always_comb begin
    if (win_id) begin
      win_req.op    = req_op[2*OPW-1:OPW];
      win_req.a     = req_a[2*XLEN-1:XLEN];
      win_req.b     = req_b[2*XLEN-1:XLEN];
      win_req.shamt = req_shamt[2*SHW-1:SHW];
    end else begin
      win_req.op    = req_op[OPW-1:0];
      win_req.a     = req_a[XLEN-1:0];
      win_req.b     = req_b[XLEN-1:0];
      win_req.shamt = req_shamt[SHW-1:0];
    end
  end

  // Grants are only offered in IDLE and never while reset is asserted
  assign req_ready = (state_q == ST_IDLE && rst_n) ? gnt : 2'b00;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    opreg_d     = opreg_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          last_d   = win_id;
          opreg_d  = win_req;
          rsp_id_d = win_id;
          if (!op_defined(win_req.op) ||
              (win_req.op == ALUOp_DIV && win_req.b == '0)) begin
            // Rejected ops skip the ALU and answer on the next cycle
            state_d     = ST_RESP;
            cnt_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_res_d   = '0;
            rsp_zero_d  = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ST_EXEC;
            cnt_d   = op_muldiv(win_req.op) ? CNTW'(MULDIV_LAT - 1) : '0;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_res_d   = alu_res;
          rsp_zero_d  = alu_zero;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      opreg_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      opreg_q     <= opreg_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

  assign alu_in1   = opreg_q.a;
  assign alu_in2   = opreg_q.b;
  assign alu_shamt = opreg_q.shamt;
  assign alu_op    = opreg_q.op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the alu_* ports, directed scenarios
// and a randomized run checked against a transaction-level arbitration model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_op, req_shamt;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_res, alu_in1, alu_in2, alu_res;
  logic [4:0]  alu_shamt, alu_op;
  logic        alu_zero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (op)
      ALUOp_ADD:  return a + b;
      ALUOp_SUB:  return a - b;
      ALUOp_AND:  return a & b;
      ALUOp_OR:   return a | b;
      ALUOp_XOR:  return a ^ b;
      ALUOp_SLL:  return a << sh;
      ALUOp_SRL:  return a >> sh;
      ALUOp_SRA:  return $unsigned($signed(a) >>> sh);
      ALUOp_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALUOp_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALUOp_MUL:  return a * b;
      ALUOp_DIV:  return (b == 32'd0) ? 32'd0 : a / b;
      ALUOp_BEQ:  return a - b;
      ALUOp_BNE:  return a - b;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic ref_zero(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    r = ref_res(op, a, b, sh);
    return (op == ALUOp_BNE) ? (r != 32'd0) : (r == 32'd0);
  endfunction

  function automatic logic ref_rejected(input logic [4:0] op, input logic [31:0] b);
    case (op)
      ALUOp_ADD, ALUOp_SUB, ALUOp_AND, ALUOp_OR, ALUOp_XOR, ALUOp_SLL, ALUOp_SRL,
      ALUOp_SRA, ALUOp_SLT, ALUOp_SLTU, ALUOp_MUL, ALUOp_BEQ, ALUOp_BNE: return 1'b0;
      ALUOp_DIV: return b == 32'd0;
      default:   return 1'b1;
    endcase
  endfunction

  // External ALU behaviour seen by the arbiter
  always_comb begin
    alu_res  = ref_res(alu_op, alu_in1, alu_in2, alu_shamt);
    alu_zero = ref_zero(alu_op, alu_in1, alu_in2, alu_shamt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
    if (id == 0) begin
      req_op[4:0] = op; req_a[31:0] = a; req_b[31:0] = b; req_shamt[4:0] = sh;
    end else begin
      req_op[9:5] = op; req_a[63:32] = a; req_b[63:32] = b; req_shamt[9:5] = sh;
    end
  endtask

  // Called just after the accept edge; lat counts cycles until rsp_valid (1 = next cycle)
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // Single-requester transaction up to the moment the response is visible
  task automatic issue(input int id, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, output int lat);
    int k;
    set_req(id, op, a, b, sh);
    req_valid[id] = 1'b1;
    #1;
    k = 0;
    while (!req_ready[id] && k < 20) begin
      tick();
      k++;
    end
    tick();
    req_valid[id] = 1'b0;
    wait_rsp(lat);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_shamt = '0;
    tick(); tick(); tick();
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready_in_rst: got %b want 00", req_ready); end
    req_valid = 2'b00;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if ({rsp_id, rsp_zero, rsp_err} !== 3'b000) begin n_bad++; $display("FAIL reset_rsp_flags: got %b want 000", {rsp_id, rsp_zero, rsp_err}); end
    n_cmp++; if (rsp_res !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_res: got %h want 0", rsp_res); end
    n_cmp++; if ({alu_in1, alu_in2, alu_shamt, alu_op} !== 74'd0) begin n_bad++; $display("FAIL reset_alu_regs: got %h/%h/%h/%h want 0", alu_in1, alu_in2, alu_shamt, alu_op); end
  endtask

  task automatic test_rr_add();
    int lat;
    rsp_ready = 1'b1;
    set_req(0, ALUOp_ADD, 32'd3, 32'd4, 5'd0);
    set_req(1, ALUOp_ADD, 32'd10, 32'd5, 5'd0);
    req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rr_first_grant: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b10;
    wait_rsp(lat);
    n_cmp++; if (rsp_id !== 1'b0 || rsp_res !== 32'd7) begin n_bad++; $display("FAIL rr_rsp0: got id %0d res %0d want id 0 res 7", rsp_id, rsp_res); end
    tick();
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL rr_second_grant: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    wait_rsp(lat);
    n_cmp++; if (rsp_id !== 1'b1 || rsp_res !== 32'd15) begin n_bad++; $display("FAIL rr_rsp1: got id %0d res %0d want id 1 res 15", rsp_id, rsp_res); end
    tick();
  endtask

  task automatic test_sub_bne();
    int lat;
    rsp_ready = 1'b1;
    issue(0, ALUOp_SUB, 32'd5, 32'd5, 5'd0, lat);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL sub_latency: got %0d want 2", lat); end
    n_cmp++; if (rsp_res !== 32'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL sub_result: got res %h zero %b err %b want 0/1/0", rsp_res, rsp_zero, rsp_err); end
    tick();
    issue(0, ALUOp_BNE, 32'd5, 32'd5, 5'd0, lat);
    n_cmp++; if (rsp_zero !== 1'b0 || lat != 2) begin n_bad++; $display("FAIL bne_zero: got zero %b lat %0d want 0 lat 2", rsp_zero, lat); end
    tick();
  endtask

  task automatic test_mul();
    int lat, bad_rdy;
    rsp_ready = 1'b1;
    set_req(0, ALUOp_ADD, 32'd1, 32'd1, 5'd0);
    set_req(1, ALUOp_MUL, 32'd6, 32'd7, 5'd0);
    req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL mul_grant: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b01;
    bad_rdy = 0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (req_ready !== 2'b00) bad_rdy++;
      tick();
      lat++;
    end
    if (req_ready !== 2'b00) bad_rdy++;
    n_cmp++; if (lat != 1 + LAT) begin n_bad++; $display("FAIL mul_latency: got %0d want %0d", lat, 1 + LAT); end
    n_cmp++; if (rsp_res !== 32'd42 || rsp_id !== 1'b1) begin n_bad++; $display("FAIL mul_result: got res %0d id %0d want 42 id 1", rsp_res, rsp_id); end
    n_cmp++; if (bad_rdy != 0) begin n_bad++; $display("FAIL mul_busy_ready: got %0d ready cycles want 0", bad_rdy); end
    tick();
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL mul_next_grant: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    wait_rsp(lat);
    n_cmp++; if (rsp_res !== 32'd2 || rsp_id !== 1'b0) begin n_bad++; $display("FAIL mul_followup: got res %0d id %0d want 2 id 0", rsp_res, rsp_id); end
    tick();
  endtask

  task automatic test_err();
    int lat;
    rsp_ready = 1'b1;
    issue(0, ALUOp_DIV, 32'd9, 32'd0, 5'd0, lat);
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL div0_latency: got %0d want 1", lat); end
    n_cmp++; if (rsp_res !== 32'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b1) begin n_bad++; $display("FAIL div0_result: got res %h zero %b err %b want 0/1/1", rsp_res, rsp_zero, rsp_err); end
    tick();
    issue(0, 5'h1F, 32'd8, 32'd2, 5'd0, lat);
    n_cmp++; if (lat != 1 || rsp_res !== 32'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b1) begin n_bad++; $display("FAIL undef_op: got lat %0d res %h zero %b err %b want 1/0/1/1", lat, rsp_res, rsp_zero, rsp_err); end
    tick();
    issue(0, ALUOp_DIV, 32'd9, 32'd2, 5'd0, lat);
    n_cmp++; if (lat != 1 + LAT || rsp_res !== 32'd4 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL div_ok: got lat %0d res %0d err %b want %0d/4/0", lat, rsp_res, rsp_err, 1 + LAT); end
    tick();
  endtask

  task automatic test_hold();
    int lat, unstable;
    logic [34:0] snap;
    rsp_ready = 1'b0;
    issue(1, ALUOp_ADD, 32'd100, 32'd23, 5'd0, lat);
    snap = {rsp_valid, rsp_id, rsp_zero, rsp_res};
    n_cmp++; if (snap !== {1'b1, 1'b1, 1'b0, 32'd123}) begin n_bad++; $display("FAIL hold_initial: got %h want %h", snap, {1'b1, 1'b1, 1'b0, 32'd123}); end
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({rsp_valid, rsp_id, rsp_zero, rsp_res} !== snap || rsp_err !== 1'b0) unstable++;
    end
    n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL hold_stable: got %0d changed cycles want 0", unstable); end
    rsp_ready = 1'b1;
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_exec();
    int seen;
    rsp_ready = 1'b1;
    set_req(0, ALUOp_MUL, 32'd3, 32'd3, 5'd0);
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_exec_no_rsp: got %0d valid cycles want 0", seen); end
    set_req(0, ALUOp_ADD, 32'd1, 32'd2, 5'd0);
    set_req(1, ALUOp_ADD, 32'd3, 32'd4, 5'd0);
    req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rst_exec_pointer: got %b want 01", req_ready); end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_random();
    logic [4:0]  p_op[2];
    logic [31:0] p_a[2], p_b[2];
    logic [4:0]  p_sh[2];
    logic        pend[2];
    logic        last;
    int          w, lat, sel, exp_lat;
    logic [1:0]  exp_rdy;
    logic [31:0] exp_res;
    logic        exp_zero, exp_err;

    rsp_ready = 1'b0;
    req_valid = 2'b00;
    do_reset();
    last = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int it = 0; it < 60; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(1, 0) == 1 || (r == 1 && !pend[0]))) begin
          sel = $urandom_range(16, 0);
          p_a[r]  = (sel > 9) ? 32'($urandom_range(1000, 0)) : $urandom;
          p_b[r]  = 32'($urandom_range(300, 1));
          p_sh[r] = 5'($urandom_range(31, 0));
          if (sel <= 13)      p_op[r] = 5'(sel);
          else if (sel == 14) begin p_op[r] = ALUOp_DIV; p_b[r] = 32'd0; end
          else                p_op[r] = 5'($urandom_range(31, 14));
          pend[r] = 1'b1;
          set_req(r, p_op[r], p_a[r], p_b[r], p_sh[r]);
        end
      end
      req_valid = {pend[1], pend[0]};
      #1;
      w = (pend[0] && pend[1]) ? (last ? 0 : 1) : (pend[1] ? 1 : 0);
      exp_rdy = (w == 1) ? 2'b10 : 2'b01;
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rand_grant it%0d: got %b want %b", it, req_ready, exp_rdy); end
      tick();
      pend[w] = 1'b0;
      req_valid[w] = 1'b0;
      last = w[0];
      exp_err  = ref_rejected(p_op[w], p_b[w]);
      exp_res  = exp_err ? 32'd0 : ref_res(p_op[w], p_a[w], p_b[w], p_sh[w]);
      exp_zero = exp_err ? 1'b1 : ref_zero(p_op[w], p_a[w], p_b[w], p_sh[w]);
      exp_lat  = exp_err ? 1 : ((p_op[w] == ALUOp_MUL || p_op[w] == ALUOp_DIV) ? 1 + LAT : 2);
      wait_rsp(lat);
      n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL rand_latency it%0d op %h: got %0d want %0d", it, p_op[w], lat, exp_lat); end
      n_cmp++;
      if (rsp_id !== w[0] || rsp_res !== exp_res || rsp_zero !== exp_zero || rsp_err !== exp_err) begin
        n_bad++;
        $display("FAIL rand_rsp it%0d op %h: got id %0d res %h zero %b err %b want id %0d res %h zero %b err %b",
                 it, p_op[w], rsp_id, rsp_res, rsp_zero, rsp_err, w, exp_res, exp_zero, exp_err);
      end
      for (int h = $urandom_range(2, 0); h > 0; h--) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_rr_add();
    test_sub_bne();
    test_mul();
    test_err();
    test_hold();
    test_reset_mid_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
